// File: rtl/dht_pkg.sv
// Shared types and helpers for the DHT single-wire reader.
package dht_pkg;

  // Reader FSM states, in protocol order.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_START_L = 4'd1,
    ST_RELEASE = 4'd2,
    ST_RESP_L  = 4'd3,
    ST_RESP_H  = 4'd4,
    ST_BIT_L   = 4'd5,
    ST_BIT_H   = 4'd6,
    ST_CHECK   = 4'd7,
    ST_ERR     = 4'd8,
    ST_HOLDOFF = 4'd9
  } dht_state_t;

  // Failure classification reported on err_code.
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_NO_RESP  = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_CHECKSUM = 2'd3
  } dht_err_t;

  // Microseconds to clock cycles at the given clock frequency.
  function automatic int unsigned us_to_cyc(input int unsigned us, input int unsigned clk_freq_hz);
    return us * (clk_freq_hz / 1_000_000);
  endfunction

endpackage

// File: rtl/dht_sync.sv
// Multi-stage synchronizer for the asynchronous sensor line; idles high like the pulled-up bus.
module dht_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;
  logic [STAGES-1:0] stage_in;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign stage_in[gi] = d;
      end else begin : g_chain
        assign stage_in[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  // Shift the pad value through the chain; reset to the released (high) level.
  always_ff @(posedge clock) begin
    if (!reset) sync_reg <= '1;
    else        sync_reg <= stage_in;
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/dht_reader.sv
// DHT11/DHT22 single-wire reader: start pulse, response/bit timing, checksum and holdoff.
module dht_reader
  import dht_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
  parameter int unsigned START_LOW_US  = 18000,
  parameter int unsigned BIT_THRESH_US = 50,
  parameter int unsigned TIMEOUT_US    = 100,
  parameter int unsigned HOLDOFF_MS    = 2000
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire         dht_bus,
  input  logic        start,
  output logic        busy,
  output logic        valid,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] humidity,
  output logic [15:0] temperature
);

  localparam int unsigned START_CYC   = us_to_cyc(START_LOW_US, CLK_FREQ_HZ);
  localparam int unsigned THRESH_CYC  = us_to_cyc(BIT_THRESH_US, CLK_FREQ_HZ);
  localparam int unsigned TIMEOUT_CYC = us_to_cyc(TIMEOUT_US, CLK_FREQ_HZ);
  localparam int unsigned HOLDOFF_CYC = us_to_cyc(HOLDOFF_MS * 1000, CLK_FREQ_HZ);
  // After release the synchronizer still shows our own start pulse for a
  // couple of cycles, and the pull-up needs time to lift the line; a sensor
  // answers no sooner than ~20 us, so ignore lows for the first 10 us.
  localparam int unsigned GUARD_CYC   = us_to_cyc(10, CLK_FREQ_HZ) + 2;

  localparam int unsigned MAX_A   = (START_CYC > TIMEOUT_CYC) ? START_CYC : TIMEOUT_CYC;
  localparam int unsigned MAX_B   = (MAX_A > HOLDOFF_CYC) ? MAX_A : HOLDOFF_CYC;
  localparam int unsigned MAX_CYC = (MAX_B > THRESH_CYC) ? MAX_B : THRESH_CYC;
  localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);

  localparam logic [TMR_W-1:0] START_TC   = TMR_W'(START_CYC - 1);
  localparam logic [TMR_W-1:0] HOLDOFF_TC = TMR_W'(HOLDOFF_CYC - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_TC = TMR_W'(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] THRESH_TC  = TMR_W'(THRESH_CYC);
  localparam logic [TMR_W-1:0] GUARD_TC   = TMR_W'(GUARD_CYC);
  localparam logic [TMR_W-1:0] TMR_MAX    = TMR_W'(MAX_CYC);

  dht_state_t       state_reg, state_next;
  dht_err_t         err_cause_reg, err_cause_next;
  dht_err_t         err_code_reg;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic             drive_low_reg;
  logic [5:0]       bit_cnt_reg;
  logic [39:0]      shift_reg;
  logic [15:0]      hum_reg, temp_reg;
  logic             valid_reg, error_reg;
  logic             bus_s;
  logic             timed_out;
  logic             bit_val;
  logic [7:0]       csum;
  logic             csum_ok;

  assign dht_bus = drive_low_reg ? 1'b0 : 1'bz;

  dht_sync #(.STAGES(2)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (dht_bus),
    .q     (bus_s)
  );

  assign timed_out = (timer_reg >= TIMEOUT_TC);
  // Timer holds the number of high cycles seen so far in BIT_H.
  assign bit_val   = (timer_reg > THRESH_TC);
  assign csum      = shift_reg[39:32] + shift_reg[31:24] + shift_reg[23:16] + shift_reg[15:8];
  assign csum_ok   = (csum == shift_reg[7:0]);

  // State, phase timer, pending error cause and the open-drain enable.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      timer_reg     <= '0;
      err_cause_reg <= ERR_NONE;
      drive_low_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      err_cause_reg <= err_cause_next;
      drive_low_reg <= (state_next == ST_START_L);
    end
  end

  // Protocol sequencing with a per-phase timeout.
  always_comb begin
    state_next     = state_reg;
    err_cause_next = err_cause_reg;
    case (state_reg)
      ST_IDLE:    if (start) state_next = ST_START_L;
      ST_START_L: if (timer_reg == START_TC) state_next = ST_RELEASE;
      ST_RELEASE: begin
        if (!bus_s && timer_reg >= GUARD_TC) state_next = ST_RESP_L;
        else if (timed_out) begin
          state_next     = ST_ERR;
          err_cause_next = ERR_NO_RESP;
        end
      end
      ST_RESP_L: begin
        if (bus_s) state_next = ST_RESP_H;
        else if (timed_out) begin
          state_next     = ST_ERR;
          err_cause_next = ERR_TIMEOUT;
        end
      end
      ST_RESP_H: begin
        if (!bus_s) state_next = ST_BIT_L;
        else if (timed_out) begin
          state_next     = ST_ERR;
          err_cause_next = ERR_TIMEOUT;
        end
      end
      ST_BIT_L: begin
        if (bus_s) state_next = ST_BIT_H;
        else if (timed_out) begin
          state_next     = ST_ERR;
          err_cause_next = ERR_TIMEOUT;
        end
      end
      ST_BIT_H: begin
        if (!bus_s) state_next = (bit_cnt_reg == 6'd0) ? ST_CHECK : ST_BIT_L;
        else if (timed_out) begin
          state_next     = ST_ERR;
          err_cause_next = ERR_TIMEOUT;
        end
      end
      ST_CHECK: begin
        if (csum_ok) state_next = ST_HOLDOFF;
        else begin
          state_next     = ST_ERR;
          err_cause_next = ERR_CHECKSUM;
        end
      end
      ST_ERR:     state_next = ST_HOLDOFF;
      ST_HOLDOFF: if (timer_reg == HOLDOFF_TC) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Phase timer restarts on every state change and saturates otherwise.
  always_comb begin
    if (state_next != state_reg) begin
      // The rising-edge cycle seen in BIT_L is the first high cycle of the bit.
      timer_next = (state_next == ST_BIT_H) ? TMR_W'(1) : '0;
    end else if (timer_reg == TMR_MAX) begin
      timer_next = timer_reg;
    end else begin
      timer_next = timer_reg + TMR_W'(1);
    end
  end

  // Bit shifting, result commit, error reporting and the one-cycle strobes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      bit_cnt_reg  <= 6'd0;
      shift_reg    <= '0;
      hum_reg      <= '0;
      temp_reg     <= '0;
      err_code_reg <= ERR_NONE;
      valid_reg    <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      valid_reg <= (state_reg == ST_CHECK) && csum_ok;
      error_reg <= (state_reg == ST_ERR);
      if (state_reg == ST_IDLE && start) begin
        bit_cnt_reg  <= 6'd39;
        err_code_reg <= ERR_NONE;
      end
      if (state_reg == ST_BIT_H && !bus_s) begin
        shift_reg <= {shift_reg[38:0], bit_val};
        if (bit_cnt_reg != 6'd0) bit_cnt_reg <= bit_cnt_reg - 6'd1;
      end
      if (state_reg == ST_CHECK && csum_ok) begin
        hum_reg  <= shift_reg[39:24];
        temp_reg <= shift_reg[23:8];
      end
      if (state_reg == ST_ERR) err_code_reg <= err_cause_reg;
    end
  end

  // Drive the handshake outputs.
  always_comb begin
    busy        = (state_reg != ST_IDLE);
    valid       = valid_reg;
    error       = error_reg;
    err_code    = err_code_reg;
    humidity    = hum_reg;
    temperature = temp_reg;
  end

endmodule

// File: tb/tb_dht_reader.sv
// Directed bench for dht_reader with a behavioural DHT sensor on a pulled-up line.
`timescale 1ns/1ps
module tb_dht_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        sensor_low = 1'b0;
  wire         dht_bus;
  logic        busy, valid, error;
  logic [1:0]  err_code;
  logic [15:0] humidity, temperature;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int error_cnt = 0;
  int both_cnt = 0;

  pullup (dht_bus);
  assign dht_bus = sensor_low ? 1'b0 : 1'bz;

  dht_reader #(
    .CLK_FREQ_HZ   (1_000_000),
    .START_LOW_US  (1000),
    .BIT_THRESH_US (50),
    .TIMEOUT_US    (100),
    .HOLDOFF_MS    (1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .dht_bus     (dht_bus),
    .start       (start),
    .busy        (busy),
    .valid       (valid),
    .error       (error),
    .err_code    (err_code),
    .humidity    (humidity),
    .temperature (temperature)
  );

  always #500 clock = ~clock;

  always @(negedge clock) begin
    if (valid === 1'b1) valid_cnt++;
    if (error === 1'b1) error_cnt++;
    if (valid === 1'b1 && error === 1'b1) both_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 10000) begin
      step(1);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  // Sensor: waits for the host start pulse, answers, then sends 40 bits MSB first.
  // stuck_bit holds the line high for 150 us at that bit; reset_bit asserts reset there.
  task automatic sensor_frame(input logic [39:0] frame, input int hi0, input int hi1,
                              input int stuck_bit, input int reset_bit, output int low_len);
    int n;
    low_len = 0;
    n = 0;
    while (dht_bus !== 1'b0 && n < 50) begin
      step(1);
      n++;
    end
    checks++;
    if (dht_bus !== 1'b0) begin
      errors++;
      $display("FAIL host_start: bus=%b, required 0 within 50 cycles", dht_bus);
      return;
    end
    while (dht_bus === 1'b0 && low_len < 5000) begin
      low_len++;
      step(1);
    end
    step(30);
    sensor_low = 1'b1; step(80);
    sensor_low = 1'b0; step(80);
    for (int i = 39; i >= 0; i--) begin
      sensor_low = 1'b1;
      if (i == reset_bit) begin
        step(10);
        reset = 1'b0;
        sensor_low = 1'b0;
        return;
      end
      step(50);
      sensor_low = 1'b0;
      if (i == stuck_bit) begin
        step(150);
        return;
      end
      step(frame[i] ? hi1 : hi0);
    end
    sensor_low = 1'b1; step(50);
    sensor_low = 1'b0;
  endtask

  task automatic test_reset();
    step(3);
    checks++;
    if ({busy, valid, error, err_code} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/valid/error/err_code=%b, required 00000", {busy, valid, error, err_code});
    end
    checks++;
    if ({humidity, temperature} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: %h, required 00000000", {humidity, temperature});
    end
    checks++;
    if (dht_bus !== 1'b1) begin
      errors++;
      $display("FAIL reset_bus: bus=%b, required 1", dht_bus);
    end
    reset = 1'b1;
    step(2);
    $display("reset: busy=%b err_code=%0d hum=%h temp=%h", busy, err_code, humidity, temperature);
  endtask

  task automatic test_good_frame();
    int v0, e0, low_len;
    v0 = valid_cnt; e0 = error_cnt;
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL good_busy_rise: busy=%b, required 1", busy);
    end
    sensor_frame(40'h350018004D, 26, 70, -1, -1, low_len);
    checks++;
    if (low_len != 1000) begin
      errors++;
      $display("FAIL good_start_width: %0d cycles, required 1000", low_len);
    end
    wait_idle("good");
    checks++;
    if (valid_cnt - v0 != 1 || error_cnt != e0) begin
      errors++;
      $display("FAIL good_pulses: valid=%0d error=%0d, required 1 and 0", valid_cnt - v0, error_cnt - e0);
    end
    checks++;
    if ({humidity, temperature, err_code} !== {16'h3500, 16'h1800, 2'd0}) begin
      errors++;
      $display("FAIL good_data: hum=%h temp=%h err=%0d, required 3500 1800 0", humidity, temperature, err_code);
    end
    $display("read good: hum=%h temp=%h err_code=%0d", humidity, temperature, err_code);
  endtask

  task automatic test_bad_checksum();
    logic [39:0] frames [2];
    int v0, e0, low_len;
    frames[0] = 40'h350018004E;
    frames[1] = 40'h7711223300;
    for (int k = 0; k < 2; k++) begin
      v0 = valid_cnt; e0 = error_cnt;
      pulse_start();
      sensor_frame(frames[k], 26, 70, -1, -1, low_len);
      wait_idle("badsum");
      checks++;
      if (error_cnt - e0 != 1 || valid_cnt != v0) begin
        errors++;
        $display("FAIL badsum_pulses[%0d]: error=%0d valid=%0d, required 1 and 0", k, error_cnt - e0, valid_cnt - v0);
      end
      checks++;
      if (err_code !== 2'd3) begin
        errors++;
        $display("FAIL badsum_code[%0d]: %0d, required 3", k, err_code);
      end
      checks++;
      if ({humidity, temperature} !== {16'h3500, 16'h1800}) begin
        errors++;
        $display("FAIL badsum_keep[%0d]: hum=%h temp=%h, required 3500 1800", k, humidity, temperature);
      end
      $display("read badsum %0d: err_code=%0d hum=%h temp=%h", k, err_code, humidity, temperature);
    end
  endtask

  task automatic test_silent();
    int n, k, v0;
    v0 = valid_cnt;
    pulse_start();
    n = 0;
    while (dht_bus === 1'b0 && n < 2000) begin
      step(1);
      n++;
    end
    k = 0;
    while (error !== 1'b1 && k < 300) begin
      step(1);
      k++;
    end
    checks++;
    if (k < 95 || k > 110) begin
      errors++;
      $display("FAIL silent_delay: error after %0d cycles, required 95..110", k);
    end
    checks++;
    if (err_code !== 2'd1) begin
      errors++;
      $display("FAIL silent_code: %0d, required 1", err_code);
    end
    step(990);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL silent_holdoff_busy: busy=%b, required 1", busy);
    end
    n = 0;
    while (busy !== 1'b0 && n < 30) begin
      step(1);
      n++;
    end
    checks++;
    if (n < 5 || n > 15) begin
      errors++;
      $display("FAIL silent_holdoff_end: busy dropped after %0d more cycles, required 5..15", n);
    end
    checks++;
    if (valid_cnt != v0 || {humidity, temperature} !== {16'h3500, 16'h1800}) begin
      errors++;
      $display("FAIL silent_keep: valid=%0d hum=%h temp=%h, required 0 3500 1800", valid_cnt - v0, humidity, temperature);
    end
    $display("read silent: err_code=%0d error_delay=%0d", err_code, k);
  endtask

  task automatic test_stuck();
    int v0, e0, low_len;
    v0 = valid_cnt; e0 = error_cnt;
    pulse_start();
    sensor_frame(40'h350018004D, 26, 70, 20, -1, low_len);
    wait_idle("stuck");
    checks++;
    if (err_code !== 2'd2) begin
      errors++;
      $display("FAIL stuck_code: %0d, required 2", err_code);
    end
    checks++;
    if (valid_cnt != v0 || error_cnt - e0 != 1) begin
      errors++;
      $display("FAIL stuck_pulses: valid=%0d error=%0d, required 0 and 1", valid_cnt - v0, error_cnt - e0);
    end
    $display("read stuck: err_code=%0d hum=%h temp=%h", err_code, humidity, temperature);
  endtask

  task automatic test_threshold();
    int v0, e0, low_len;
    v0 = valid_cnt; e0 = error_cnt;
    pulse_start();
    checks++;
    if (err_code !== 2'd0) begin
      errors++;
      $display("FAIL thresh_err_clear: %0d, required 0", err_code);
    end
    fork
      sensor_frame(40'h010203040A, 50, 51, -1, -1, low_len);
      begin
        step(2000);
        pulse_start();
      end
    join
    wait_idle("thresh");
    step(100);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL thresh_no_queue: busy=%b, required 0", busy);
    end
    checks++;
    if (valid_cnt - v0 != 1 || error_cnt != e0) begin
      errors++;
      $display("FAIL thresh_pulses: valid=%0d error=%0d, required 1 and 0", valid_cnt - v0, error_cnt - e0);
    end
    checks++;
    if ({humidity, temperature} !== {16'h0102, 16'h0304}) begin
      errors++;
      $display("FAIL thresh_data: hum=%h temp=%h, required 0102 0304", humidity, temperature);
    end
    $display("read threshold: hum=%h temp=%h err_code=%0d", humidity, temperature, err_code);
  endtask

  task automatic test_reset_mid_frame();
    int v0, low_len;
    pulse_start();
    step(100);
    checks++;
    if (dht_bus !== 1'b0) begin
      errors++;
      $display("FAIL rst_start_drive: bus=%b, required 0", dht_bus);
    end
    reset = 1'b0;
    step(1);
    checks++;
    if (dht_bus !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_start_release: bus=%b busy=%b, required 1 0", dht_bus, busy);
    end
    reset = 1'b1;
    step(2);
    pulse_start();
    sensor_frame(40'h350018004D, 26, 70, -1, 10, low_len);
    step(1);
    checks++;
    if (dht_bus !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_bus: bus=%b, required 1", dht_bus);
    end
    checks++;
    if ({busy, valid, error, err_code} !== 5'b0 || {humidity, temperature} !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: ctrl=%b data=%h, required 00000 00000000",
               {busy, valid, error, err_code}, {humidity, temperature});
    end
    reset = 1'b1;
    step(2);
    v0 = valid_cnt;
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_restart_busy: busy=%b, required 1", busy);
    end
    sensor_frame(40'h350018004D, 26, 70, -1, -1, low_len);
    wait_idle("rst_restart");
    checks++;
    if (valid_cnt - v0 != 1 || {humidity, temperature, err_code} !== {16'h3500, 16'h1800, 2'd0}) begin
      errors++;
      $display("FAIL rst_restart_read: valid=%0d hum=%h temp=%h err=%0d, required 1 3500 1800 0",
               valid_cnt - v0, humidity, temperature, err_code);
    end
    $display("read after reset: hum=%h temp=%h err_code=%0d", humidity, temperature, err_code);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_silent();
    test_stuck();
    test_threshold();
    test_reset_mid_frame();
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL valid_error_overlap: %0d cycles, required 0", both_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
